// File: rtl/rom_rd_pkg.sv
// Shared types and constants for the boot-ROM burst reader.
package rom_rd_pkg;

    // Controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Response buffer depth: covers one word in flight from the ROM plus two
    // buffered words, so a full-rate stream never has to stall on credit.
    localparam int RSP_DEPTH = 3;
    localparam int RSP_CNT_W = 2;

    // Response entry layout for the default 32-bit ROM. The top builds a
    // parameterised entry with the same field order for other widths.
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rsp_entry_t;

endpackage

// File: rtl/rom_rsp_fifo.sv
// Three-entry synchronous FIFO buffering ROM words on their way to the consumer.
module rom_rsp_fifo
    import rom_rd_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic [RSP_CNT_W-1:0] count_o,
    output logic                 empty_o,
    output logic                 full_o
);

    logic [WIDTH-1:0]     mem_q [RSP_DEPTH];
    logic [RSP_CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RSP_CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [RSP_CNT_W-1:0] count_q, count_d;
    logic                 do_pop;

    function automatic logic [RSP_CNT_W-1:0] ptr_inc(input logic [RSP_CNT_W-1:0] p);
        return (p == RSP_CNT_W'(RSP_DEPTH - 1)) ? '0 : p + RSP_CNT_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == RSP_CNT_W'(RSP_DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + RSP_CNT_W'(1);
            2'b01:   count_d = count_q - RSP_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read controller in front of the single-port boot ROM.
//
//   state | meaning
//   IDLE  | waiting for a burst request; req_ready high
//   ISSUE | one ROM read per cycle while credit allows; back to IDLE after the last
module rom_burst_reader
    import rom_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rom_ce,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  busy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  issue;
    logic                  issue_last;
    logic                  credit_ok;

    entry_t                fifo_wdata;
    entry_t                fifo_head;
    logic [RSP_CNT_W-1:0]  fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_pop;

    // Outstanding words are those buffered plus the one the ROM is returning.
    // A pop in the same cycle is deliberately not counted as free space.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'(RSP_DEPTH);

    // Next-state, address/beat bookkeeping and ROM issue decision.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        req_ready  = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    beats_d = req_len;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue   = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    beats_d = beats_q - LEN_WIDTH'(1);
                    if (beats_q == '0) begin
                        issue_last = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset discards any burst in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            beats_q         <= '0;
            rom_addr_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            beats_q         <= beats_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            if (issue) rom_addr_q <= addr_q;
        end
    end

    // rom_addr follows the issuing address and holds it between issues.
    assign rom_ce   = issue;
    assign rom_addr = issue ? addr_q : rom_addr_q;

    assign fifo_wdata = '{data: rom_dout, last: inflight_last_q};
    assign fifo_pop   = rsp_valid & rsp_ready;

    rom_rsp_fifo #(
        .WIDTH ($bits(entry_t))
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push_i  (inflight_q),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_data  = fifo_head.data;
    assign rsp_last  = fifo_head.last;
    assign busy      = (state_q != IDLE) | inflight_q | (fifo_count != '0);

    // The credit rule must keep the buffer from ever overflowing.
    assert property (@(posedge clk) disable iff (!resetn) !(inflight_q && fifo_full))
        else $error("response buffer push while full");

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a registered ROM model.
module tb_rom_burst_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rom_ce;
    logic [7:0]  rom_addr;
    logic [31:0] rom_dout = '0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom_mem [256];

    always #5 clk = ~clk;

    // ROM model: registered read, data valid the cycle after ce.
    always @(posedge clk) if (rom_ce) rom_dout <= rom_mem[rom_addr];

    rom_burst_reader dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .busy      (busy)
    );

    // Present a request at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic send_req(input logic [7:0] a, input logic [3:0] l);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_rom_ce got=%b want=0", rom_ce); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr got=%h want=00", rom_addr); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got=%b want=0", rsp_last); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_single();
        rom_mem[5] = 32'h0000_2197;
        send_req(8'h05, 4'd0);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            checks++; if (rom_ce !== (c == 1)) begin errors++; $display("FAIL single_rom_ce cycle=%0d got=%b want=%b", c, rom_ce, (c == 1)); end
            if (c == 1) begin
                checks++; if (rom_addr !== 8'h05) begin errors++; $display("FAIL single_rom_addr got=%h want=05", rom_addr); end
            end
            checks++; if (rsp_valid !== (c == 3)) begin errors++; $display("FAIL single_rsp_valid cycle=%0d got=%b want=%b", c, rsp_valid, (c == 3)); end
            if (c == 3) begin
                checks++; if (rsp_data !== 32'h0000_2197) begin errors++; $display("FAIL single_rsp_data got=%h want=00002197", rsp_data); end
                checks++; if (rsp_last !== 1'b1) begin errors++; $display("FAIL single_rsp_last got=%b want=1", rsp_last); end
            end
            if (c >= 4) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy cycle=%0d got=%b want=0", c, busy); end
            end
        end
        rom_mem[5] = 32'd5;
    endtask

    task automatic test_streaming();
        send_req(8'h10, 4'd15);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            checks++; if (rom_ce !== (c <= 16)) begin errors++; $display("FAIL stream_rom_ce cycle=%0d got=%b want=%b", c, rom_ce, (c <= 16)); end
            checks++; if (rsp_valid !== (c >= 3 && c <= 18)) begin errors++; $display("FAIL stream_rsp_valid cycle=%0d got=%b", c, rsp_valid); end
            if (c >= 3 && c <= 18) begin
                checks++; if (rsp_data !== 32'(c + 13)) begin errors++; $display("FAIL stream_rsp_data cycle=%0d got=%h want=%h", c, rsp_data, 32'(c + 13)); end
                checks++; if (rsp_last !== (c == 18)) begin errors++; $display("FAIL stream_rsp_last cycle=%0d got=%b want=%b", c, rsp_last, (c == 18)); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        int n_ce  = 0;
        int nbeat = 0;
        rsp_ready = 1'b0;
        send_req(8'h00, 4'd7);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 10) rsp_ready = 1'b1;
            if (c < 10 && rom_ce) n_ce++;
            if (c >= 3 && c < 10) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_last !== 1'b0) begin
                    errors++; $display("FAIL bp_hold cycle=%0d got valid=%b data=%h last=%b want 1/0/0", c, rsp_valid, rsp_data, rsp_last);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++; if (rsp_data !== 32'(nbeat)) begin errors++; $display("FAIL bp_data beat=%0d got=%h want=%h", nbeat, rsp_data, 32'(nbeat)); end
                checks++; if (rsp_last !== (nbeat == 7)) begin errors++; $display("FAIL bp_last beat=%0d got=%b want=%b", nbeat, rsp_last, (nbeat == 7)); end
                checks++; if (c != 10 + nbeat) begin errors++; $display("FAIL bp_gap beat=%0d got cycle=%0d want cycle=%0d", nbeat, c, 10 + nbeat); end
                nbeat++;
            end
        end
        checks++; if (n_ce != 3) begin errors++; $display("FAIL bp_issue_count got=%0d want=3", n_ce); end
        checks++; if (nbeat != 8) begin errors++; $display("FAIL bp_beat_count got=%0d want=8", nbeat); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [4];
        int nbeat = 0;
        exp_w = '{32'h0000_00FE, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0001};
        send_req(8'hFE, 4'd3);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (nbeat < 4) begin
                    checks++; if (rsp_data !== exp_w[nbeat]) begin errors++; $display("FAIL wrap_data beat=%0d got=%h want=%h", nbeat, rsp_data, exp_w[nbeat]); end
                    checks++; if (rsp_last !== (nbeat == 3)) begin errors++; $display("FAIL wrap_last beat=%0d got=%b want=%b", nbeat, rsp_last, (nbeat == 3)); end
                end
                nbeat++;
            end
        end
        checks++; if (nbeat != 4) begin errors++; $display("FAIL wrap_beat_count got=%0d want=4", nbeat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [4];
        int          exp_c [4];
        int acc_a = -1;
        int acc_b = -1;
        int nbeat = 0;
        logic pend_a = 1'b0;
        logic pend_b = 1'b0;
        exp_d = '{32'h0, 32'h1, 32'h40, 32'h41};
        exp_c = '{3, 4, 6, 7};
        req_valid = 1'b1;
        req_addr  = 8'h00;
        req_len   = 4'd1;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk);
            if (pend_a) begin req_addr = 8'h40; req_len = 4'd1; pend_a = 1'b0; end
            if (pend_b) begin req_valid = 1'b0; pend_b = 1'b0; end
            if (req_valid && req_ready) begin
                if (acc_a < 0) begin acc_a = c; pend_a = 1'b1; end
                else begin acc_b = c; pend_b = 1'b1; end
            end
            if (rsp_valid && rsp_ready) begin
                if (nbeat < 4) begin
                    checks++; if (rsp_data !== exp_d[nbeat]) begin errors++; $display("FAIL b2b_data beat=%0d got=%h want=%h", nbeat, rsp_data, exp_d[nbeat]); end
                    checks++; if (rsp_last !== (nbeat == 1 || nbeat == 3)) begin errors++; $display("FAIL b2b_last beat=%0d got=%b", nbeat, rsp_last); end
                    checks++; if (c != exp_c[nbeat]) begin errors++; $display("FAIL b2b_cycle beat=%0d got=%0d want=%0d", nbeat, c, exp_c[nbeat]); end
                end
                nbeat++;
            end
        end
        req_valid = 1'b0;
        checks++; if (acc_a != 0) begin errors++; $display("FAIL b2b_accept_a got=%0d want=0", acc_a); end
        checks++; if (acc_b != 3) begin errors++; $display("FAIL b2b_accept_b got=%0d want=3", acc_b); end
        checks++; if (nbeat != 4) begin errors++; $display("FAIL b2b_beat_count got=%0d want=4", nbeat); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        send_req(8'h00, 4'd7);
        for (int c = 2; c <= 6; c++) @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h3) begin errors++; $display("FAIL rmid_beat4 got valid=%b data=%h want 1/3", rsp_valid, rsp_data); end
        resetn = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0 || rsp_last !== 1'b0) begin errors++; $display("FAIL rmid_rsp_data got=%h last=%b want 0/0", rsp_data, rsp_last); end
        checks++; if (rom_ce !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_ce_busy got ce=%b busy=%b want 0/0", rom_ce, busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_req_ready got=%b want=1", req_ready); end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || rom_ce !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rmid_after_release bad_cycles=%0d want=0", stray); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'(i);
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
